// File: rtl/buffer_escrita.sv
// buffer_escrita: store buffer between the CPU load/store path and a
// single-port data memory. Stores are queued in a small FIFO and drained on
// cycles the port is not needed by a load; loads go straight to memory.
//
// Compile-time option BUFFER_ESCRITA_FWD_EN:
//   defined   - loads that hit pending stores are forwarded from the buffer
//               (youngest matching entry wins).
//   undefined - a load that hits a pending store stalls, and the port is
//               given to the drain until no matching entry remains.
module buffer_escrita #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cpu_write,
  input  logic                    cpu_read,
  input  logic [ADDR_W-1:0]       cpu_endereco,
  input  logic [DATA_W-1:0]       cpu_dado_in,
  output logic [DATA_W-1:0]       cpu_dado_out,
  output logic                    stall,
  output logic                    mem_write,
  output logic                    mem_read,
  output logic [ADDR_W-1:0]       mem_index,
  output logic [DATA_W-1:0]       mem_dado_entrada,
  input  logic [DATA_W-1:0]       mem_dado_saida,
  output logic                    vazio,
  output logic [$clog2(DEPTH):0]  ocupacao
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // FIFO state
  logic [PW-1:0]     head_reg, head_next;
  logic [PW-1:0]     tail_reg, tail_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Per-slot view ordered oldest (0) to youngest (DEPTH-1)
  logic [PW-1:0]     slot_idx [DEPTH];
  logic [DEPTH-1:0]  slot_match;

  logic              not_empty;
  logic              stall_load;
  logic              stall_store;
  logic              load_served;
  logic              drain;
  logic              push;
  logic [DATA_W-1:0] load_data;

  // Slot k sits k positions after the head; it only counts while occupied.
  // The store presented this cycle is not yet in the array, so it never
  // participates in matching.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi]   = head_reg + PW'(gi);
      assign slot_match[gi] = (CW'(gi) < count_reg) &&
                              (addr_mem[slot_idx[gi]] == cpu_endereco);
    end
  endgenerate

`ifdef BUFFER_ESCRITA_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Scan oldest to youngest so the last (youngest) match overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_match[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[slot_idx[k]];
      end
    end
  end

  assign stall_load = 1'b0;
  assign load_data  = fwd_hit ? fwd_data : mem_dado_saida;
`else
  // Without forwarding a hitting load must wait for its stores to reach memory.
  assign stall_load = cpu_read && (|slot_match);
  assign load_data  = mem_dado_saida;
`endif

  assign not_empty   = (count_reg != '0);
  assign load_served = cpu_read && !stall_load;
  assign drain       = not_empty && !load_served;
  // A store riding along with a stalled load is held back too, otherwise the
  // CPU's retry of the pair would enqueue the store a second time.
  assign push        = cpu_write && !stall_load &&
                       ((count_reg < FULL_COUNT) || drain);
  assign stall_store = cpu_write && !push;

  // Next pointers and occupancy; push and pop in one cycle leave count alone.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (drain) begin
      head_next = head_reg + PW'(1);
    end
    if (push) begin
      tail_next = tail_reg + PW'(1);
    end
    case ({push, drain})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; reset discards every pending store.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage written at the tail; contents are qualified by count.
  always_ff @(posedge clock) begin
    if (push && reset_n) begin
      addr_mem[tail_reg] <= cpu_endereco;
      data_mem[tail_reg] <= cpu_dado_in;
    end
  end

  // Port mux and CPU-side outputs; everything is quiet while reset is held.
  always_comb begin
    stall            = 1'b0;
    mem_write        = 1'b0;
    mem_read         = 1'b0;
    mem_index        = '0;
    mem_dado_entrada = '0;
    cpu_dado_out     = '0;
    if (reset_n) begin
      stall     = stall_store || stall_load;
      mem_write = drain;
      mem_read  = load_served;
      if (not_empty) begin
        mem_index        = addr_mem[head_reg];
        mem_dado_entrada = data_mem[head_reg];
      end
      if (load_served) begin
        mem_index = cpu_endereco;
      end
      if (cpu_read) begin
        cpu_dado_out = load_data;
      end
    end
  end

  assign vazio    = !not_empty;
  assign ocupacao = count_reg;

endmodule

// File: tb/tb_buffer_escrita.sv
// Self-checking bench for buffer_escrita. The reference model is a queue of
// pending {addr,data} stores plus an image of memory; expectations come from
// the buffer's rules applied to that queue each cycle.
module tb_buffer_escrita;

  localparam int DEPTH = 4;
`ifdef BUFFER_ESCRITA_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cpu_write, cpu_read;
  logic [7:0] cpu_endereco, cpu_dado_in;
  logic [7:0] cpu_dado_out;
  logic       stall, mem_write, mem_read;
  logic [7:0] mem_index, mem_dado_entrada, mem_dado_saida;
  logic       vazio;
  logic [2:0] ocupacao;

  // Environment memory (combinational read, write at the edge)
  logic [7:0] tb_mem [256];
  logic       tb_set;
  logic [7:0] tb_set_a, tb_set_d;

  // Reference model
  ent_t       q[$];
  logic [7:0] ref_mem [256];
  logic       exp_drain, exp_push, exp_stall, exp_stall_load;
  logic       exp_mem_write, exp_mem_read, exp_served;
  logic [7:0] exp_index, exp_wdata, exp_dout;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) tb_mem[mem_index] <= mem_dado_entrada;
    if (tb_set)    tb_mem[tb_set_a]  <= tb_set_d;
  end
  assign mem_dado_saida = tb_mem[mem_index];

  buffer_escrita #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu_write        (cpu_write),
    .cpu_read         (cpu_read),
    .cpu_endereco     (cpu_endereco),
    .cpu_dado_in      (cpu_dado_in),
    .cpu_dado_out     (cpu_dado_out),
    .stall            (stall),
    .mem_write        (mem_write),
    .mem_read         (mem_read),
    .mem_index        (mem_index),
    .mem_dado_entrada (mem_dado_entrada),
    .mem_dado_saida   (mem_dado_saida),
    .vazio            (vazio),
    .ocupacao         (ocupacao)
  );

  // Apply a request and derive what the buffer must do from the queue.
  task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    bit         hit;
    logic [7:0] young;
    cpu_write    = w;
    cpu_read     = r;
    cpu_endereco = a;
    cpu_dado_in  = d;
    hit   = 1'b0;
    young = 8'h00;
    foreach (q[i]) begin
      if (q[i].a == a) begin
        hit   = 1'b1;
        young = q[i].d;
      end
    end
    exp_stall_load = !FWD && r && hit;
    exp_served     = r && !exp_stall_load;
    exp_drain      = (q.size() > 0) && !exp_served;
    exp_push       = w && !exp_stall_load && ((q.size() < DEPTH) || exp_drain);
    exp_stall      = (w && !exp_push) || exp_stall_load;
    exp_mem_write  = exp_drain;
    exp_mem_read   = exp_served;
    exp_wdata      = (q.size() > 0) ? q[0].d : 8'h00;
    exp_index      = exp_served ? a : ((q.size() > 0) ? q[0].a : 8'h00);
    exp_dout       = !r ? 8'h00 : ((FWD && hit) ? young : ref_mem[a]);
    #2;
  endtask

  // Advance one clock and apply the model's pop/push.
  task automatic tick();
    ent_t e;
    e.a = cpu_endereco;
    e.d = cpu_dado_in;
    @(posedge clock);
    if (exp_drain) begin
      ref_mem[q[0].a] = q[0].d;
      q.delete(0);
    end
    if (exp_push) q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_endereco = 8'h03; cpu_dado_in = 8'hAA;
    #2;
    checks++; if (ocupacao !== 3'd0) begin errors++; $display("FAIL reset_ocupacao got=%0d exp=0", ocupacao); end
    checks++; if (vazio !== 1'b1) begin errors++; $display("FAIL reset_vazio got=%b exp=1", vazio); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem got=%b%b exp=00", mem_write, mem_read); end
    checks++; if (cpu_dado_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", cpu_dado_out); end
    cpu_write = 1'b0; cpu_read = 1'b0;
    reset_n = 1'b1;
    q.delete();
    @(posedge clock); #1;
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (vazio !== 1'b1 || ocupacao !== 3'd0) begin errors++; $display("FAIL post_reset_empty got=%b/%0d exp=1/0", vazio, ocupacao); end
    tick();
  endtask

  task automatic test_single_store();
    drive(1, 0, 8'h04, 8'h09);
    checks++; if (stall !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL single_accept stall=%b mem_write=%b exp=0/0", stall, mem_write); end
    tick();
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL single_mem_write got=%b exp=1", mem_write); end
    checks++; if (mem_index !== 8'h04) begin errors++; $display("FAIL single_mem_index got=%h exp=04", mem_index); end
    checks++; if (mem_dado_entrada !== 8'h09) begin errors++; $display("FAIL single_mem_data got=%h exp=09", mem_dado_entrada); end
    checks++; if (ocupacao !== 3'd1) begin errors++; $display("FAIL single_ocupacao got=%0d exp=1", ocupacao); end
    tick();
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (vazio !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL single_drained vazio=%b mem_write=%b exp=1/0", vazio, mem_write); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(4 + i), 8'(8'h30 + i));
      checks++; if (stall !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL fill_%0d stall=%b mem_read=%b exp=0/1", i, stall, mem_read); end
      checks++; if (cpu_dado_out !== exp_dout) begin errors++; $display("FAIL fill_load_%0d got=%h exp=%h", i, cpu_dado_out, exp_dout); end
      tick();
    end
    checks++; if (ocupacao !== 3'd4) begin errors++; $display("FAIL full_ocupacao got=%0d exp=4", ocupacao); end
    drive(1, 1, 8'h08, 8'h55);
    checks++; if (stall !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL full_stall stall=%b mem_read=%b exp=1/1", stall, mem_read); end
    tick();
    drive(1, 0, 8'h08, 8'h55);
    checks++; if (stall !== 1'b0 || mem_write !== 1'b1) begin errors++; $display("FAIL full_pushpop stall=%b mem_write=%b exp=0/1", stall, mem_write); end
    checks++; if (mem_index !== 8'h04 || mem_dado_entrada !== 8'h30) begin errors++; $display("FAIL full_drain_head got=%h/%h exp=04/30", mem_index, mem_dado_entrada); end
    tick();
    checks++; if (ocupacao !== 3'd4) begin errors++; $display("FAIL full_after_pushpop got=%0d exp=4", ocupacao); end
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      drive(0, 0, 8'h00, 8'h00);
      checks++;
      if (mem_write !== 1'b1 || mem_index !== exp_index || mem_dado_entrada !== exp_wdata) begin
        errors++; $display("FAIL full_drain_%0d got=%b/%h/%h exp=1/%h/%h", n, mem_write, mem_index, mem_dado_entrada, exp_index, exp_wdata);
      end
      tick();
    end
    checks++; if (vazio !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", vazio); end
  endtask

  task automatic test_forward();
    int  n;
    bit  done;
    drive(1, 0, 8'h05, 8'h08); tick();
    drive(1, 0, 8'h05, 8'h07); tick();
    n = 0;
    done = 1'b0;
    while (!done && n < 8) begin
      drive(0, 1, 8'h05, 8'h00);
      if (stall === 1'b0) begin
        done = 1'b1;
      end else begin
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL fwd_stall_%0d got=%b exp=%b", n, stall, exp_stall); end
        tick();
        n++;
      end
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_timeout stall=%b exp=0", stall); end
    checks++; if (cpu_dado_out !== 8'h07) begin errors++; $display("FAIL fwd_data got=%h exp=07", cpu_dado_out); end
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL fwd_port got=%b%b exp=10", mem_read, mem_write); end
`ifdef BUFFER_ESCRITA_FWD_EN
    checks++; if (n != 0) begin errors++; $display("FAIL fwd_stall_cycles got=%0d exp=0", n); end
`else
    checks++; if (n != 1) begin errors++; $display("FAIL fwd_stall_cycles got=%0d exp=1", n); end
`endif
    tick();
  endtask

  task automatic test_load_empty();
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      drive(0, 0, 8'h00, 8'h00); tick();
    end
    tb_set = 1'b1; tb_set_a = 8'h02; tb_set_d = 8'h05; ref_mem[2] = 8'h05;
    drive(0, 0, 8'h00, 8'h00); tick();
    tb_set = 1'b0;
    drive(0, 1, 8'h02, 8'h00);
    checks++; if (cpu_dado_out !== 8'h05) begin errors++; $display("FAIL load_empty_data got=%h exp=05", cpu_dado_out); end
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL load_empty_port got=%b%b exp=10", mem_read, mem_write); end
    checks++; if (mem_index !== 8'h02) begin errors++; $display("FAIL load_empty_index got=%h exp=02", mem_index); end
    tick();
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (cpu_dado_out !== 8'h00) begin errors++; $display("FAIL idle_dout got=%h exp=00", cpu_dado_out); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] da [10];
    for (int i = 0; i < 10; i++) begin
      da[i] = 8'($urandom);
      drive(1, 0, 8'(8'h20 + i), da[i]);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wrap_stall_%0d got=%b exp=0", i, stall); end
      if (i > 0) begin
        checks++;
        if (mem_write !== 1'b1 || mem_index !== 8'(8'h20 + i - 1) || mem_dado_entrada !== da[i-1]) begin
          errors++; $display("FAIL wrap_order_%0d got=%b/%h/%h exp=1/%h/%h", i, mem_write, mem_index, mem_dado_entrada, 8'(8'h20 + i - 1), da[i-1]);
        end
      end
      tick();
      checks++; if (ocupacao !== 3'd1) begin errors++; $display("FAIL wrap_ocupacao_%0d got=%0d exp=1", i, ocupacao); end
    end
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (mem_write !== 1'b1 || mem_index !== 8'h29 || mem_dado_entrada !== da[9]) begin
      errors++; $display("FAIL wrap_last got=%b/%h/%h exp=1/29/%h", mem_write, mem_index, mem_dado_entrada, da[9]);
    end
    tick();
    checks++; if (tb_mem[8'h25] !== da[5]) begin errors++; $display("FAIL wrap_mem got=%h exp=%h", tb_mem[8'h25], da[5]); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] snap11, snap12;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'(8'h10 + i), 8'(8'hC0 + i)); tick();
    end
    checks++; if (ocupacao !== 3'd3) begin errors++; $display("FAIL mid_fill got=%0d exp=3", ocupacao); end
    drive(0, 0, 8'h00, 8'h00);
    checks++; if (mem_write !== 1'b1 || mem_index !== 8'h10) begin errors++; $display("FAIL mid_first_drain got=%b/%h exp=1/10", mem_write, mem_index); end
    tick();
    snap11 = tb_mem[8'h11];
    snap12 = tb_mem[8'h12];
    drive(0, 0, 8'h00, 8'h00);
    reset_n = 1'b0;
    #1;
    checks++; if (ocupacao !== 3'd0 || vazio !== 1'b1) begin errors++; $display("FAIL mid_reset_state got=%0d/%b exp=0/1", ocupacao, vazio); end
    checks++; if (mem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs got=%b/%b exp=0/0", mem_write, stall); end
    q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 8'h00, 8'h00);
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_after_write_%0d got=%b exp=0", n, mem_write); end
      tick();
    end
    checks++; if (tb_mem[8'h10] !== 8'hC0) begin errors++; $display("FAIL mid_mem10 got=%h exp=c0", tb_mem[8'h10]); end
    checks++; if (tb_mem[8'h11] !== snap11 || tb_mem[8'h12] !== snap12) begin
      errors++; $display("FAIL mid_no_late_write got=%h/%h exp=%h/%h", tb_mem[8'h11], tb_mem[8'h12], snap11, snap12);
    end
  endtask

  task automatic test_random();
    logic       w, r, last_stall, last_stall_load;
    logic [7:0] a, d;
    last_stall = 1'b0; last_stall_load = 1'b0;
    w = 1'b0; r = 1'b0; a = 8'h00; d = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (last_stall && last_stall_load) begin
        // hold the whole request
      end else if (last_stall) begin
        r = 1'b0;  // the load went through; only the store retries
      end else begin
        w = ($urandom_range(0, 99) < 50);
        r = ($urandom_range(0, 99) < 40);
        a = 8'(8'h40 + $urandom_range(0, 5));
        d = 8'($urandom);
      end
      drive(w, r, a, d);
      checks++;
      if (stall !== exp_stall || mem_write !== exp_mem_write || mem_read !== exp_mem_read || mem_index !== exp_index) begin
        errors++; $display("FAIL rand_port_%0d got=%b%b%b/%h exp=%b%b%b/%h", c, stall, mem_write, mem_read, mem_index, exp_stall, exp_mem_write, exp_mem_read, exp_index);
      end
      if (!exp_served) begin
        checks++; if (mem_dado_entrada !== exp_wdata) begin errors++; $display("FAIL rand_wdata_%0d got=%h exp=%h", c, mem_dado_entrada, exp_wdata); end
      end
      if (!exp_stall_load) begin
        checks++; if (cpu_dado_out !== exp_dout) begin errors++; $display("FAIL rand_dout_%0d got=%h exp=%h", c, cpu_dado_out, exp_dout); end
      end
      checks++;
      if (ocupacao !== 3'(q.size()) || vazio !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_occ_%0d got=%0d/%b exp=%0d", c, ocupacao, vazio, q.size());
      end
      last_stall = exp_stall;
      last_stall_load = exp_stall_load;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cpu_write = 1'b0; cpu_read = 1'b0; cpu_endereco = 8'h00; cpu_dado_in = 8'h00;
    tb_set = 1'b0; tb_set_a = 8'h00; tb_set_d = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tb_set = 1'b1;
      tb_set_a = 8'(i);
      tb_set_d = 8'($urandom);
      ref_mem[i] = tb_set_d;
      @(posedge clock); #1;
    end
    tb_set = 1'b0;
    test_reset();
    test_single_store();
    test_full();
    test_forward();
    test_load_empty();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
